// File: rtl/hsv_core_pkg.sv
// Shared hsv_core types: token, register and word widths, plus the commit-stage result record.
package hsv_core_pkg;

  localparam int TOKEN_W   = 4;
  localparam int NUM_UNITS = 5;

  localparam int UNIT_ALU        = 0;
  localparam int UNIT_FOO        = 1;
  localparam int UNIT_MEM        = 2;
  localparam int UNIT_BRANCH     = 3;
  localparam int UNIT_CTRLSTATUS = 4;

  typedef logic [TOKEN_W-1:0] insn_token;
  typedef logic [4:0]         reg_addr;
  typedef logic [31:0]        reg_mask;
  typedef logic [31:0]        word;

  typedef struct packed {
    insn_token token;
    word       pc;
    reg_addr   rd_addr;
    reg_mask   rd_mask;
    word       rd_value;
    logic      writeback;
    logic      redirect;
    word       redirect_pc;
  } commit_data_t;

endpackage

// File: rtl/hsv_core_commit_select.sv
// Combinational token-match selector: grants the lowest-index valid unit whose token equals next_token.
module hsv_core_commit_select
  import hsv_core_pkg::*;
#(
  parameter int N = NUM_UNITS
) (
  input  logic      [N-1:0] i_valid,
  input  insn_token [N-1:0] i_token,
  input  insn_token         i_next_token,
  output logic      [N-1:0] o_grant,
  output logic              o_found,
  output logic              o_multi
);

  logic [N-1:0] w_match;
  logic         w_taken;

  always_comb begin
    w_match = '0;
    o_grant = '0;
    w_taken = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_match[i] = i_valid[i] && (i_token[i] == i_next_token);
      if (w_match[i] && !w_taken) begin
        o_grant[i] = 1'b1;
        w_taken    = 1'b1;
      end
    end
    o_found = w_taken;
    // Clearing the lowest set bit leaves something only if two or more units matched.
    o_multi = (w_match & (w_match - {{(N-1){1'b0}}, 1'b1})) != '0;
  end

endmodule

// File: rtl/hsv_core_commit.sv
// In-order commit stage: retires one token-ordered result per cycle, drives register-file write,
// scoreboard release mask and a one-cycle flush on redirect.
module hsv_core_commit
  import hsv_core_pkg::*;
(
  input  logic                         clk_core,
  input  logic                         rst_core_n,
  input  logic         [NUM_UNITS-1:0] unit_valid_i,
  output logic         [NUM_UNITS-1:0] unit_ready_o,
  input  commit_data_t [NUM_UNITS-1:0] unit_data,
  output logic                         wr_en,
  output reg_addr                      wr_addr,
  output word                          wr_data,
  output reg_mask                      commit_mask,
  output logic                         flush_req,
  output word                          flush_pc,
  output logic         [63:0]          retire_count
);

  insn_token            r_next_token;
  logic                 r_wr_en;
  reg_addr              r_wr_addr;
  word                  r_wr_data;
  reg_mask              r_commit_mask;
  logic                 r_flush_req;
  word                  r_flush_pc;
  logic [63:0]          r_retire_count;

  insn_token    [NUM_UNITS-1:0] w_tokens;
  logic         [NUM_UNITS-1:0] w_grant;
  logic                         w_found;
  logic                         w_multi;
  logic                         w_commit;
  commit_data_t                 w_sel;
  logic                         w_unused_fields;

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_tokens[i] = unit_data[i].token;
    end
  end

  hsv_core_commit_select #(.N(NUM_UNITS)) u_select (
    .i_valid      (unit_valid_i),
    .i_token      (w_tokens),
    .i_next_token (r_next_token),
    .o_grant      (w_grant),
    .o_found      (w_found),
    .o_multi      (w_multi)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_grant[i]) w_sel = unit_data[i];
    end
    w_commit = w_found && !r_flush_req;
    // During the flush cycle every unit is acknowledged so wrong-path results drain.
    unit_ready_o = r_flush_req ? '1 : w_grant;
  end

  assign w_unused_fields = ^{w_sel.pc, w_sel.token};

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_next_token   <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_commit_mask  <= '0;
      r_flush_req    <= 1'b0;
      r_flush_pc     <= '0;
      r_retire_count <= '0;
    end else begin
      r_wr_en       <= w_commit && w_sel.writeback && (w_sel.rd_addr != '0);
      r_commit_mask <= w_commit ? w_sel.rd_mask : '0;
      r_flush_req   <= w_commit && w_sel.redirect;
      if (w_commit) begin
        r_wr_addr      <= w_sel.rd_addr;
        r_wr_data      <= w_sel.rd_value;
        r_retire_count <= r_retire_count + 64'd1;
        if (w_sel.redirect) begin
          r_flush_pc   <= w_sel.redirect_pc;
          r_next_token <= '0;
        end else begin
          r_next_token <= r_next_token + insn_token'(1);
        end
      end else if (r_flush_req) begin
        r_next_token <= '0;
      end
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign commit_mask  = r_commit_mask;
  assign flush_req    = r_flush_req;
  assign flush_pc     = r_flush_pc;
  assign retire_count = r_retire_count;

  a_single_match: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    !(w_multi && !r_flush_req));

endmodule

// File: tb/tb_hsv_core_commit.sv
// Directed bench for hsv_core_commit: ordering, stalls, x0 writes, redirect flush, token wrap, async reset.
module tb_hsv_core_commit;
  import hsv_core_pkg::*;

  logic                         clk_core;
  logic                         rst_core_n;
  logic         [NUM_UNITS-1:0] unit_valid_i;
  logic         [NUM_UNITS-1:0] unit_ready_o;
  commit_data_t [NUM_UNITS-1:0] unit_data;
  logic                         wr_en;
  reg_addr                      wr_addr;
  word                          wr_data;
  reg_mask                      commit_mask;
  logic                         flush_req;
  word                          flush_pc;
  logic [63:0]                  retire_count;

  int n_chk = 0;
  int n_bad = 0;

  hsv_core_commit dut (
    .clk_core     (clk_core),
    .rst_core_n   (rst_core_n),
    .unit_valid_i (unit_valid_i),
    .unit_ready_o (unit_ready_o),
    .unit_data    (unit_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit_mask  (commit_mask),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .retire_count (retire_count)
  );

  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_u(input int u, input insn_token tok, input reg_addr rd, input word val,
                       input logic wb, input logic redir, input word rpc);
    unit_data[u].token       = tok;
    unit_data[u].pc          = 32'h1000 + 32'(u);
    unit_data[u].rd_addr     = rd;
    unit_data[u].rd_mask     = reg_mask'(1) << rd;
    unit_data[u].rd_value    = val;
    unit_data[u].writeback   = wb;
    unit_data[u].redirect    = redir;
    unit_data[u].redirect_pc = rpc;
    unit_valid_i[u]          = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  insn_token tok;
  int        u;
  reg_addr   rd;

  initial begin
    rst_core_n   = 1'b0;
    unit_valid_i = '0;
    unit_data    = '0;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_mask", 64'(commit_mask), 64'd0);
    chk("rst_flush", 64'(flush_req), 64'd0);
    chk("rst_flush_pc", 64'(flush_pc), 64'd0);
    chk("rst_retire", retire_count, 64'd0);
    chk("rst_ready", 64'(unit_ready_o), 64'd0);
    #11 rst_core_n = 1'b1;

    // In-order pair presented together
    @(negedge clk_core);
    set_u(UNIT_ALU, 4'd0, 5'd5, 32'h11, 1'b1, 1'b0, 32'h0);
    set_u(UNIT_MEM, 4'd1, 5'd6, 32'h22, 1'b1, 1'b0, 32'h0);
    #1 chk("pair_ready0", 64'(unit_ready_o), 64'h01);
    tick();
    chk("pair_wr_en0", 64'(wr_en), 64'd1);
    chk("pair_addr0", 64'(wr_addr), 64'd5);
    chk("pair_data0", 64'(wr_data), 64'h11);
    chk("pair_mask0", 64'(commit_mask), 64'h20);
    unit_valid_i[UNIT_ALU] = 1'b0;
    #1 chk("pair_ready1", 64'(unit_ready_o), 64'h04);
    tick();
    chk("pair_addr1", 64'(wr_addr), 64'd6);
    chk("pair_data1", 64'(wr_data), 64'h22);
    chk("pair_mask1", 64'(commit_mask), 64'h40);
    chk("pair_retire", retire_count, 64'd2);
    unit_valid_i[UNIT_MEM] = 1'b0;
    tick();
    chk("idle_wr_en", 64'(wr_en), 64'd0);
    chk("idle_mask", 64'(commit_mask), 64'd0);

    // Out-of-order: branch token 3 waits for alu token 2
    @(negedge clk_core);
    set_u(UNIT_BRANCH, 4'd3, 5'd8, 32'h33, 1'b1, 1'b0, 32'h0);
    #1 chk("ooo_stall_ready_a", 64'(unit_ready_o), 64'h00);
    tick();
    chk("ooo_stall_wr_en", 64'(wr_en), 64'd0);
    chk("ooo_stall_retire", retire_count, 64'd2);
    @(negedge clk_core);
    #1 chk("ooo_stall_ready_b", 64'(unit_ready_o), 64'h00);
    tick();
    @(negedge clk_core);
    set_u(UNIT_ALU, 4'd2, 5'd7, 32'h44, 1'b1, 1'b0, 32'h0);
    #1 chk("ooo_alu_ready", 64'(unit_ready_o), 64'h01);
    tick();
    chk("ooo_alu_addr", 64'(wr_addr), 64'd7);
    unit_valid_i[UNIT_ALU] = 1'b0;
    #1 chk("ooo_br_ready", 64'(unit_ready_o), 64'h08);
    tick();
    chk("ooo_br_addr", 64'(wr_addr), 64'd8);
    chk("ooo_br_data", 64'(wr_data), 64'h33);
    chk("ooo_retire", retire_count, 64'd4);
    unit_valid_i[UNIT_BRANCH] = 1'b0;

    // Writeback to x0: no write, scoreboard still released
    @(negedge clk_core);
    set_u(UNIT_ALU, 4'd4, 5'd0, 32'h99, 1'b1, 1'b0, 32'h0);
    tick();
    chk("x0_wr_en", 64'(wr_en), 64'd0);
    chk("x0_mask", 64'(commit_mask), 64'd1);
    chk("x0_retire", retire_count, 64'd5);
    unit_valid_i[UNIT_ALU] = 1'b0;

    // Redirect from branch token 5 with alu token 6 pending
    @(negedge clk_core);
    set_u(UNIT_BRANCH, 4'd5, 5'd9, 32'h55, 1'b1, 1'b1, 32'h400);
    set_u(UNIT_ALU, 4'd6, 5'd12, 32'h66, 1'b1, 1'b0, 32'h0);
    #1 chk("redir_ready", 64'(unit_ready_o), 64'h08);
    tick();
    chk("redir_flush", 64'(flush_req), 64'd1);
    chk("redir_pc", 64'(flush_pc), 64'h400);
    chk("redir_own_wr_en", 64'(wr_en), 64'd1);
    chk("redir_own_addr", 64'(wr_addr), 64'd9);
    chk("redir_retire", retire_count, 64'd6);
    unit_valid_i[UNIT_BRANCH] = 1'b0;
    #1 chk("flush_ready_all", 64'(unit_ready_o), 64'h1f);
    tick();
    unit_valid_i[UNIT_ALU] = 1'b0;
    chk("flush_drop", 64'(flush_req), 64'd0);
    chk("drain_wr_en", 64'(wr_en), 64'd0);
    chk("drain_mask", 64'(commit_mask), 64'd0);
    chk("drain_retire", retire_count, 64'd6);
    @(negedge clk_core);
    set_u(UNIT_ALU, 4'd0, 5'd10, 32'h77, 1'b1, 1'b0, 32'h0);
    #1 chk("post_flush_ready", 64'(unit_ready_o), 64'h01);
    tick();
    chk("post_flush_addr", 64'(wr_addr), 64'd10);
    chk("post_flush_data", 64'(wr_data), 64'h77);
    chk("post_flush_mask", 64'(commit_mask), 64'h400);
    chk("post_flush_retire", retire_count, 64'd7);
    unit_valid_i[UNIT_ALU] = 1'b0;

    // Token wrap: 2^TOKEN_W + 3 back-to-back commits across rotating units
    tok = 4'd1;
    for (int k = 0; k < (1 << TOKEN_W) + 3; k++) begin
      u  = k % NUM_UNITS;
      rd = reg_addr'((k % 31) + 1);
      @(negedge clk_core);
      set_u(u, tok, rd, 32'h1000 + 32'(k), 1'b1, 1'b0, 32'h0);
      #1 chk("wrap_ready", 64'(unit_ready_o), 64'(1) << u);
      tick();
      chk("wrap_data", 64'(wr_data), 64'h1000 + 64'(k));
      unit_valid_i[u] = 1'b0;
      tok = tok + 4'd1;
    end
    chk("wrap_retire", retire_count, 64'd26);

    // Async reset while a matching result is presented
    @(negedge clk_core);
    set_u(UNIT_ALU, tok, 5'd11, 32'hab, 1'b1, 1'b0, 32'h0);
    #1 chk("pre_rst_ready", 64'(unit_ready_o), 64'h01);
    #1 rst_core_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
    chk("mid_rst_mask", 64'(commit_mask), 64'd0);
    chk("mid_rst_flush_pc", 64'(flush_pc), 64'd0);
    chk("mid_rst_retire", retire_count, 64'd0);
    chk("mid_rst_ready", 64'(unit_ready_o), 64'h00);
    @(negedge clk_core);
    rst_core_n = 1'b1;
    #1 chk("post_rst_ready", 64'(unit_ready_o), 64'h00);
    tick();
    chk("post_rst_retire", retire_count, 64'd0);
    chk("post_rst_wr_en", 64'(wr_en), 64'd0);
    @(negedge clk_core);
    unit_data[UNIT_ALU].token = 4'd0;
    #1 chk("tok0_ready", 64'(unit_ready_o), 64'h01);
    tick();
    chk("tok0_addr", 64'(wr_addr), 64'd11);
    chk("tok0_data", 64'(wr_data), 64'hab);
    chk("tok0_retire", retire_count, 64'd1);
    unit_valid_i[UNIT_ALU] = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
